turn_timer: RTL

TURN_TIMER -- requirements
Module: turn_timer

---
 rtl/game_pkg.sv | 30 +++
 rtl/tick_prescaler.sv | 51 +++++
 rtl/turn_timer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game timing blocks.
//   timer_state_t    : states of the turn countdown FSM
//   TURN_SECONDS_DEF : default length of one player turn, in seconds
//   CLK_HZ           : system clock frequency, also the default tick divider
//   sec_dec()        : saturating one-second decrement of a seconds value
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam int TURN_SECONDS_DEF = 10;
  localparam int CLK_HZ           = 50_000_000;

  // Decrement that stops at zero, so a stray tick can never wrap the
  // display value round to 15.
  function automatic logic [3:0] sec_dec(input logic [3:0] s);
    if (s == 4'd0) begin
      return 4'd0;
    end
    return s - 4'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a one-second tick.
//   clk    : system clock
//   rst    : asynchronous active-high reset, counter to 0
//   clear  : synchronous clear of the counter (wins over enable)
//   enable : counter advances while high, holds its value while low
//   tick   : high for the one cycle in which the counter wraps
// The counter runs 0..TICK_DIV-1; tick is decoded from the last count so
// the consumer sees it on the same edge that wraps the counter back to 0.
// ---------------------------------------------------------------------------
module tick_prescaler
  import game_pkg::*;
#(
  parameter int TICK_DIV = CLK_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // A divider of 1 would give a zero-width counter, so keep at least 1 bit.
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // The tick is suppressed while clearing so a start or abort landing on
  // the wrap cycle never also produces a decrement.
  assign tick = enable && !clear && (count == LAST);

  // Counter: clear has priority, then advance-and-wrap while enabled.
  // With enable low the partial count is kept, which is what lets a
  // paused turn resume exactly where it stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_timer.sv
// ---------------------------------------------------------------------------
// turn_timer
// Per-turn countdown timer for the game controller.
//   clk     : system clock, all state on its rising edge
//   rst     : asynchronous active-high reset, back to IDLE
//   start   : one-cycle pulse, reload TURN_SECONDS and run
//   pause   : level, freezes the countdown while high
//   abort   : one-cycle pulse, return to IDLE
//   seconds : remaining seconds, to the seven-segment seconds input
//   running : high in RUN only
//   expired : high in EXPIRED only
//   timeout : one-cycle pulse on entry to EXPIRED
// Inputs are prioritised abort > start > pause > tick. All outputs are
// registers written in the FSM block, so nothing reaches an output
// combinationally from an input.
// ---------------------------------------------------------------------------
module turn_timer
  import game_pkg::*;
#(
  parameter int TICK_DIV     = CLK_HZ,
  parameter int TURN_SECONDS = TURN_SECONDS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] seconds,
  output logic       running,
  output logic       expired,
  output logic       timeout
);

  // TURN_SECONDS is expected in 1..15 so it fits the 4-bit display value.
  localparam logic [3:0] SEC_INIT = 4'(TURN_SECONDS);

  timer_state_t state;
  logic         pre_clear;
  logic         pre_enable;
  logic         tick;

  // The prescaler is held at 0 in IDLE and cleared on every start/abort so
  // each fresh turn gets a full first second. It is also enabled in PAUSED
  // (when pause has dropped) so the release edge already counts, keeping the
  // total time per second at exactly TICK_DIV counting edges across a pause.
  assign pre_clear  = abort || start || (state == IDLE);
  assign pre_enable = ((state == RUN) || (state == PAUSED)) && !pause;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (pre_clear),
    .enable (pre_enable),
    .tick   (tick)
  );

  // Turn FSM with its seconds register and registered status outputs.
  // timeout defaults low every cycle and is only raised on the edge that
  // enters EXPIRED, which makes it a single-cycle pulse by construction.
  // Leaving PAUSED on a tick cycle is handled like RUN so a second that
  // completes on the release edge is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      seconds <= SEC_INIT;
      running <= 1'b0;
      expired <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        seconds <= SEC_INIT;
        running <= 1'b0;
        expired <= 1'b0;
      end else if (start) begin
        state   <= RUN;
        seconds <= SEC_INIT;
        running <= 1'b1;
        expired <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            seconds <= SEC_INIT;
          end
          RUN, PAUSED: begin
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick && (seconds <= 4'd1)) begin
              state   <= EXPIRED;
              seconds <= 4'd0;
              running <= 1'b0;
              expired <= 1'b1;
              timeout <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
              if (tick) begin
                seconds <= sec_dec(seconds);
              end
            end
          end
          EXPIRED: begin
            seconds <= 4'd0;
          end
          default: begin
            state   <= IDLE;
            seconds <= SEC_INIT;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
